// File: rtl/fnd_scan_if.sv
// Scanned FND display bus plus the decoded-frame outputs of the scan receiver.
// master = scan source / bench side, slave = receiver side.
interface fnd_scan_if;
    logic [7:0]  i_font;
    logic [3:0]  i_digit;
    logic [15:0] o_value;
    logic [3:0]  o_dp;
    logic        o_valid;
    logic        o_font_err;
    logic        o_stalled;

    modport master (
        output i_font, i_digit,
        input  o_value, o_dp, o_valid, o_font_err, o_stalled
    );

    modport slave (
        input  i_font, i_digit,
        output o_value, o_dp, o_valid, o_font_err, o_stalled
    );
endinterface

// File: rtl/fnd_scan_receiver.sv
// Receives a multiplexed 4-digit FND scan, debounces each digit position and
// decodes the segment fonts back into a BCD frame that is published once all slots are seen.
module fnd_scan_receiver #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    fnd_scan_if.slave   bus
);
    // state     | meaning
    // S_COLLECT | gathering digit captures into the slot registers
    // S_PUBLISH | one cycle: copy slots to outputs, pulse o_valid
    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_PUBLISH = 1'b1;

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [7:0]        font_s1_q, font_s2_q;
    logic [3:0]        digit_s1_q, digit_s2_q;
    logic [11:0]       prev_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [0:0]        state_q, state_d;
    logic [3:0][3:0]   slot_q, slot_d;
    logic [3:0]        sdp_q, sdp_d;
    logic [3:0]        mask_q, mask_d;
    logic              acc_q, acc_d;
    logic [15:0]       value_q, value_d;
    logic [3:0]        dp_q, dp_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [11:0]       pair_s;
    logic              hit;
    logic              sel_ok;
    logic [1:0]        sel_idx;
    logic [3:0]        nib;
    logic              nib_bad;
    logic              capture;

    function automatic logic [4:0] decode_font(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b0, 4'd0};
            7'h79:   r = {1'b0, 4'd1};
            7'h24:   r = {1'b0, 4'd2};
            7'h30:   r = {1'b0, 4'd3};
            7'h19:   r = {1'b0, 4'd4};
            7'h12:   r = {1'b0, 4'd5};
            7'h02:   r = {1'b0, 4'd6};
            7'h78:   r = {1'b0, 4'd7};
            7'h00:   r = {1'b0, 4'd8};
            7'h10:   r = {1'b0, 4'd9};
            default: r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    always_comb begin
        pair_s = {digit_s2_q, font_s2_q};
        if (pair_s != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        // fires only on the transition into the saturated count, so a held pattern captures once
        hit = (cnt_d == STABLE_MAX) && (cnt_q != STABLE_MAX);
    end

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (digit_s2_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
        {nib_bad, nib} = decode_font(font_s2_q[6:0]);
        capture = hit && sel_ok;
    end

    always_comb begin
        slot_d  = slot_q;
        sdp_d   = sdp_q;
        mask_d  = mask_q;
        acc_d   = acc_q;
        state_d = state_q;
        value_d = value_q;
        dp_d    = dp_q;
        err_d   = err_q;
        valid_d = 1'b0;
        tmo_d   = (tmo_q != TIMEOUT_MAX) ? tmo_q + TW'(1) : tmo_q;

        if (state_q == S_PUBLISH) begin
            value_d = slot_q;
            dp_d    = sdp_q;
            err_d   = acc_q;
            valid_d = 1'b1;
            mask_d  = 4'b0000;
            acc_d   = 1'b0;
            state_d = S_COLLECT;
        end

        if (capture) begin
            tmo_d            = '0;
            slot_d[sel_idx]  = nib;
            sdp_d[sel_idx]   = ~font_s2_q[7];
            mask_d[sel_idx]  = 1'b1;
            if (nib_bad) begin
                acc_d = 1'b1;
            end
            if ((state_q == S_COLLECT) && (mask_d == 4'b1111)) begin
                state_d = S_PUBLISH;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            font_s1_q  <= '0;
            font_s2_q  <= '0;
            digit_s1_q <= '0;
            digit_s2_q <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            state_q    <= S_COLLECT;
            slot_q     <= '0;
            sdp_q      <= '0;
            mask_q     <= '0;
            acc_q      <= 1'b0;
            value_q    <= '0;
            dp_q       <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            font_s1_q  <= bus.i_font;
            font_s2_q  <= font_s1_q;
            digit_s1_q <= bus.i_digit;
            digit_s2_q <= digit_s1_q;
            prev_q     <= pair_s;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            slot_q     <= slot_d;
            sdp_q      <= sdp_d;
            mask_q     <= mask_d;
            acc_q      <= acc_d;
            value_q    <= value_d;
            dp_q       <= dp_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_value    = value_q;
    assign bus.o_dp       = dp_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_font_err = err_q;
    assign bus.o_stalled  = (tmo_q >= TIMEOUT_MAX);
endmodule

// File: tb/tb_fnd_scan_receiver.sv
// Directed bench for fnd_scan_receiver: scans known frames and checks the
// published value, dp, error flag, pulse count and stall behaviour.
module tb_fnd_scan_receiver;
    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   pulses = 0;

    always #5 clk = ~clk;

    fnd_scan_if bus();

    fnd_scan_receiver #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) pulses++;
    end

    task automatic hold(input logic [3:0] d, input logic [7:0] f, input int n);
        bus.i_digit = d;
        bus.i_font  = f;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [7:0] f0, input logic [7:0] f1,
                         input logic [7:0] f2, input logic [7:0] f3);
        hold(4'b1110, f0, 8);
        hold(4'b1101, f1, 8);
        hold(4'b1011, f2, 8);
        hold(4'b0111, f3, 8);
        hold(4'b1111, 8'hFF, 4);
    endtask

    task automatic test_reset();
        logic [24:0] got;
        bus.i_digit = 4'b1111;
        bus.i_font  = 8'hFF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        got = {bus.o_value, bus.o_dp, bus.o_valid, bus.o_font_err, bus.o_stalled, 1'b0};
        tests_run++;
        if (got !== 25'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h", got, 25'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_scan();
        int p0;
        p0 = pulses;
        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        tests_run++;
        if ({bus.o_value, bus.o_dp, bus.o_font_err} !== {16'h1234, 4'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL scan_frame: got %h/%h/%b expected 1234/0/0", bus.o_value, bus.o_dp, bus.o_font_err);
        end
        tests_run++;
        if (pulses - p0 !== 1) begin
            tests_failed++;
            $display("FAIL scan_pulse: got %0d expected 1", pulses - p0);
        end
        p0 = pulses;
        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        tests_run++;
        if (pulses - p0 !== 2 || bus.o_value !== 16'h1234) begin
            tests_failed++;
            $display("FAIL scan_repeat: got %0d pulses value %h expected 2 pulses value 1234", pulses - p0, bus.o_value);
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulses;
        hold(4'b1110, 8'h99, 8);
        hold(4'b1101, 8'hB0, 8);
        hold(4'b1101, 8'h80, 2);
        hold(4'b1101, 8'hB0, 8);
        hold(4'b1011, 8'hA4, 8);
        hold(4'b0111, 8'hF9, 8);
        hold(4'b1111, 8'hFF, 4);
        tests_run++;
        if (bus.o_value !== 16'h1234 || pulses - p0 !== 1) begin
            tests_failed++;
            $display("FAIL glitch_recapture: got %h/%0d expected 1234/1", bus.o_value, pulses - p0);
        end
        p0 = pulses;
        hold(4'b1110, 8'h99, 8);
        hold(4'b1101, 8'hB0, 8);
        hold(4'b1101, 8'h80, 2);
        hold(4'b1011, 8'hA4, 8);
        hold(4'b0111, 8'hF9, 8);
        hold(4'b1111, 8'hFF, 4);
        tests_run++;
        if (bus.o_value !== 16'h1234 || pulses - p0 !== 1) begin
            tests_failed++;
            $display("FAIL glitch_tail: got %h/%0d expected 1234/1", bus.o_value, pulses - p0);
        end
    endtask

    task automatic test_bad_font();
        scan4(8'h99, 8'hB0, 8'hFF, 8'hF9);
        tests_run++;
        if ({bus.o_value, bus.o_dp, bus.o_font_err} !== {16'h1F34, 4'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL bad_font: got %h/%h/%b expected 1f34/0/1", bus.o_value, bus.o_dp, bus.o_font_err);
        end
        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        tests_run++;
        if ({bus.o_value, bus.o_font_err} !== {16'h1234, 1'b0}) begin
            tests_failed++;
            $display("FAIL bad_font_clear: got %h/%b expected 1234/0", bus.o_value, bus.o_font_err);
        end
    endtask

    task automatic test_interleave();
        int p0;
        p0 = pulses;
        hold(4'b1110, 8'h00, 8);
        hold(4'b1111, 8'hFF, 8);
        hold(4'b1101, 8'hB0, 8);
        hold(4'b1100, 8'h80, 8);
        hold(4'b1011, 8'hA4, 8);
        hold(4'b1111, 8'h99, 8);
        hold(4'b0111, 8'hF9, 8);
        hold(4'b1111, 8'hFF, 4);
        tests_run++;
        if ({bus.o_value, bus.o_dp, bus.o_font_err} !== {16'h1238, 4'b0001, 1'b0}) begin
            tests_failed++;
            $display("FAIL interleave_frame: got %h/%b/%b expected 1238/0001/0", bus.o_value, bus.o_dp, bus.o_font_err);
        end
        tests_run++;
        if (pulses - p0 !== 1) begin
            tests_failed++;
            $display("FAIL interleave_pulse: got %0d expected 1", pulses - p0);
        end
    endtask

    task automatic test_stall();
        hold(4'b1111, 8'hFF, 40);
        tests_run++;
        if (bus.o_stalled !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_early: got %b expected 0", bus.o_stalled);
        end
        hold(4'b1111, 8'hFF, 80);
        tests_run++;
        if (bus.o_stalled !== 1'b1 || bus.o_value !== 16'h1238) begin
            tests_failed++;
            $display("FAIL stall_set: got %b/%h expected 1/1238", bus.o_stalled, bus.o_value);
        end
        hold(4'b1110, 8'h99, 8);
        tests_run++;
        if (bus.o_stalled !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_clear: got %b expected 0", bus.o_stalled);
        end
        hold(4'b1101, 8'hB0, 8);
        hold(4'b1011, 8'hA4, 8);
        hold(4'b0111, 8'hF9, 8);
        hold(4'b1111, 8'hFF, 4);
        tests_run++;
        if (bus.o_value !== 16'h1234) begin
            tests_failed++;
            $display("FAIL stall_resume: got %h expected 1234", bus.o_value);
        end
    endtask

    task automatic test_reset_midframe();
        int p0;
        logic [24:0] got;
        hold(4'b1110, 8'h99, 8);
        hold(4'b1101, 8'hB0, 8);
        hold(4'b1011, 8'hA4, 8);
        bus.i_digit = 4'b1111;
        bus.i_font  = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        got = {bus.o_value, bus.o_dp, bus.o_valid, bus.o_font_err, bus.o_stalled, 1'b0};
        tests_run++;
        if (got !== 25'h0) begin
            tests_failed++;
            $display("FAIL reset_midframe_outputs: got %h expected %h", got, 25'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        p0 = pulses;
        hold(4'b0111, 8'h12, 8);
        hold(4'b1011, 8'h02, 8);
        hold(4'b1101, 8'h78, 8);
        hold(4'b1111, 8'hFF, 4);
        tests_run++;
        if (pulses - p0 !== 0) begin
            tests_failed++;
            $display("FAIL reset_partial: got %0d pulses expected 0", pulses - p0);
        end
        hold(4'b1110, 8'h40, 8);
        hold(4'b1111, 8'hFF, 4);
        tests_run++;
        if (pulses - p0 !== 1 || bus.o_value !== 16'h5670) begin
            tests_failed++;
            $display("FAIL reset_fresh_frame: got %0d/%h expected 1/5670", pulses - p0, bus.o_value);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_glitch();
        test_bad_font();
        test_interleave();
        test_stall();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
